vga_mode_sequencer: RTL and testbench
=====================================

Name: vga_mode_sequencer

Overview:
- Sequences resolution changes into the VGA Config register block.
- Arbitrates mode-change requests from two requesters: A = board switches, B = host command path.
- Writes the Config mode register only at a frame boundary, waits for Config's Load_config strobe, then blanks video for a settle period.
- Sits between the requesters and Config, alongside the VGA timing generator.

Parameters:
- CONFIG_WIDTH, 2: width of Config Addr/Data and of mode codes.
- MODE_ADDR, 2'b10: Config address of the mode register.
- NUM_MODES, 3: valid mode codes are 0..NUM_MODES-1 (0=6x4 default, 1=8x6, 2=10x86).
- DEFAULT_MODE, 0: mode Config holds after reset.
- SETTLE_FRAMES, 2: frames blanked after a successful load (>=1).
- LOAD_TIMEOUT, 16: cycles allowed for Load_config after a write (>=2).

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous reset, active-high
- Req_a  in  1  requester A mode-change request
- Mode_a  in  CONFIG_WIDTH  requested mode, stable while Req_a=1
- Ack_a  out  1  one-cycle completion pulse to A
- Req_b  in  1  requester B mode-change request
- Mode_b  in  CONFIG_WIDTH  requested mode, stable while Req_b=1
- Ack_b  out  1  one-cycle completion pulse to B
- Status  out  1  result, valid with Ack_a/Ack_b: 1=applied/already active, 0=rejected
- Frame_end  in  1  one-cycle pulse from timing generator at start of vertical blank
- Load_config  in  1  pulse from Config: new timings latched
- Cfg_valid  out  1  write strobe to Config Valid
- Cfg_addr  out  CONFIG_WIDTH  to Config Addr
- Cfg_data  out  CONFIG_WIDTH  to Config Data
- Blank  out  1  force RGB black
- Busy  out  1  state != IDLE
- Cur_mode  out  CONFIG_WIDTH  mode currently applied

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE; Cur_mode=DEFAULT_MODE.
  - Cfg_valid, Blank, Ack_a, Ack_b, Status, Busy all 0; Cfg_addr=0, Cfg_data=0.
  - RR pointer favours A.
  - Config shares this reset, so Cur_mode stays consistent with it.
- All outputs are Moore, decoded from registered state and registered data.
- Handshake:
  - Requester raises Req with Mode and holds both until it sees Ack=1.
  - Requester drops Req on that same edge.
  - Req is sampled only in IDLE.
- Arbitration (IDLE):
  - If one Req is high, it is granted.
  - If both are high, the RR-favoured one is granted; the pointer then favours the other.
  - On grant: latch pend_mode and grant id.
- IDLE next state:
  - pend_mode>=NUM_MODES -> RESP, Status=0.
  - pend_mode==Cur_mode -> RESP, Status=1. No Config write; Ack appears the cycle after grant.
  - Otherwise -> WAIT_FRAME.
- WAIT_FRAME:
  - Blank=0.
  - On Frame_end -> WRITE.
- WRITE (exactly one cycle):
  - Cfg_valid=1, Cfg_addr=MODE_ADDR, Cfg_data=pend_mode, Blank=1.
  - Timer cleared -> WAIT_LOAD.
- WAIT_LOAD:
  - Blank=1; timer increments each cycle.
  - Load_config=1 -> Cur_mode<=pend_mode, frame counter cleared -> SETTLE.
  - Timer==LOAD_TIMEOUT-1 with no Load_config -> RESP, Status=0; Cur_mode unchanged.
  - If Load_config and the timeout cycle coincide, the load wins.
- SETTLE:
  - Blank=1; counts Frame_end pulses.
  - On the SETTLE_FRAMES-th pulse -> RESP, Status=1.
- RESP (one cycle):
  - Ack of the granted requester=1, Status driven, Blank=0 -> IDLE.
- Ignored inputs:
  - Frame_end in IDLE, WRITE, WAIT_LOAD and RESP.
  - Load_config outside WAIT_LOAD.
- Simultaneous Load_config and Frame_end in WAIT_LOAD: the Frame_end does not count toward settle.
- A non-granted Req stays pending. It is served in the first IDLE after RESP, so there is no starvation.
- Cfg_addr/Cfg_data hold their last values when Cfg_valid=0.
- Timer width is clog2(LOAD_TIMEOUT); frame counter width is clog2(SETTLE_FRAMES+1). Both saturate, never wrap.
- Reset mid-operation: immediate return to reset values; no Ack issued; any half-done change is abandoned.

Decomposition:
- Shared include alongside the width parameters:
  - CONFIG_WIDTH, MODE_ADDR.
  - Mode code constants MODE_6X4=0, MODE_8X6=1, MODE_10X86=2.
  - State encodings IDLE, WAIT_FRAME, WRITE, WAIT_LOAD, SETTLE, RESP.
- One sub-module: rr_arbiter2 (two-requester round-robin grant with pointer update on accept).

Test Plan:
- Reset, then Req_a with Mode_a=1; Frame_end 5 cycles later; Load_config 3 cycles after the write -> Cfg_valid one cycle with Addr=2'b10, Data=2'b01; Blank=1 from the write through SETTLE; Ack_a with Status=1 on the 2nd following Frame_end; Cur_mode=1.
- Req_b with Mode_b=0 while Cur_mode=0 -> no Cfg_valid; Ack_b with Status=1 one cycle after grant; Blank stays 0.
- Req_a with Mode_a=2'b11 -> Ack_a with Status=0; no write; Cur_mode unchanged.
- Req_a and Req_b raised in the same cycle with Mode_a=2, Mode_b=1 -> A served first (write Data=2'b10); B served next (Data=2'b01). Repeat the simultaneous raise -> B served first.
- Write issued with Load_config never asserted -> Ack with Status=0 after 16 cycles in WAIT_LOAD; Blank drops; Cur_mode unchanged.
- Rst asserted during SETTLE -> all outputs at reset values immediately; Cur_mode=0; no Ack.

Source files
------------

// File: rtl/vga_mode_sequencer_pkg.sv
// Shared widths, Config addresses, mode codes and sequencer state encoding
// for the VGA mode-change sequencer.
package vga_mode_sequencer_pkg;

    localparam int unsigned CONFIG_WIDTH = 2;
    localparam logic [CONFIG_WIDTH-1:0] MODE_ADDR = 2'b10;

    localparam logic [CONFIG_WIDTH-1:0] MODE_6X4   = 2'd0;
    localparam logic [CONFIG_WIDTH-1:0] MODE_8X6   = 2'd1;
    localparam logic [CONFIG_WIDTH-1:0] MODE_10X86 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_WRITE,
        ST_WAIT_LOAD,
        ST_SETTLE,
        ST_RESP
    } state_e;

    // Video is forced black from the Config write until the settle period ends
    function automatic logic is_blank_state(input state_e s);
        return (s == ST_WRITE) || (s == ST_WAIT_LOAD) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/vga_mode_sequencer_arb.sv
// Two-requester round-robin arbiter; the preference only flips when both
// requesters contend and the grant is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic prefer_b_q;
    logic prefer_b_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_b_q <= 1'b0;
        end else begin
            prefer_b_q <= prefer_b_d;
        end
    end

    always_comb begin
        grant_c    = req;
        prefer_b_d = prefer_b_q;
        if (req == 2'b11) begin
            grant_c = prefer_b_q ? 2'b10 : 2'b01;
            if (accept) begin
                prefer_b_d = !prefer_b_q;
            end
        end
    end

endmodule

// File: rtl/vga_mode_sequencer.sv
// Arbitrates mode-change requests and sequences the Config mode write at a
// frame boundary, waiting for the load and blanking through a settle period.
module vga_mode_sequencer
    import vga_mode_sequencer_pkg::*;
#(
    parameter int unsigned                NUM_MODES     = 3,
    parameter logic [CONFIG_WIDTH-1:0]    DEFAULT_MODE  = MODE_6X4,
    parameter int unsigned                SETTLE_FRAMES = 2,
    parameter int unsigned                LOAD_TIMEOUT  = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Req_a,
    input  logic [CONFIG_WIDTH-1:0] Mode_a,
    output logic                    Ack_a,
    input  logic                    Req_b,
    input  logic [CONFIG_WIDTH-1:0] Mode_b,
    output logic                    Ack_b,
    output logic                    Status,
    input  logic                    Frame_end,
    input  logic                    Load_config,
    output logic                    Cfg_valid,
    output logic [CONFIG_WIDTH-1:0] Cfg_addr,
    output logic [CONFIG_WIDTH-1:0] Cfg_data,
    output logic                    Blank,
    output logic                    Busy,
    output logic [CONFIG_WIDTH-1:0] Cur_mode
);

    localparam int unsigned TIMER_W = $clog2(LOAD_TIMEOUT);
    localparam int unsigned FRAME_W = $clog2(SETTLE_FRAMES + 1);

    state_e                  state_q, state_d;
    logic [CONFIG_WIDTH-1:0] pend_mode_q, pend_mode_d;
    logic [CONFIG_WIDTH-1:0] cur_mode_q, cur_mode_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [FRAME_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic                    gnt_b_q, gnt_b_d;
    logic                    status_q, status_d;
    logic                    ack_a_q, ack_a_d;
    logic                    ack_b_q, ack_b_d;
    logic                    cfg_valid_q, cfg_valid_d;
    logic [CONFIG_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [CONFIG_WIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                    blank_q, blank_d;
    logic                    busy_q, busy_d;

    logic [1:0]              grant_c;
    logic [CONFIG_WIDTH-1:0] sel_mode_c;
    logic                    arb_accept_c;

    assign arb_accept_c = (state_q == ST_IDLE);
    assign sel_mode_c   = grant_c[1] ? Mode_b : Mode_a;

    rr_arbiter2 u_arb (
        .clk     (Clk),
        .rst     (Rst),
        .req     ({Req_b, Req_a}),
        .accept  (arb_accept_c),
        .grant_c (grant_c)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            pend_mode_q <= '0;
            cur_mode_q  <= DEFAULT_MODE;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            gnt_b_q     <= 1'b0;
            status_q    <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            blank_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_mode_q <= pend_mode_d;
            cur_mode_q  <= cur_mode_d;
            timer_q     <= timer_d;
            frame_cnt_q <= frame_cnt_d;
            gnt_b_q     <= gnt_b_d;
            status_q    <= status_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            blank_q     <= blank_d;
            busy_q      <= busy_d;
        end
    end

    // Next state; output flops are decoded from the next state so they line up with it
    always_comb begin
        state_d     = state_q;
        pend_mode_d = pend_mode_q;
        cur_mode_d  = cur_mode_q;
        timer_d     = timer_q;
        frame_cnt_d = frame_cnt_q;
        gnt_b_d     = gnt_b_q;
        status_d    = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_c != 2'b00) begin
                    gnt_b_d     = grant_c[1];
                    pend_mode_d = sel_mode_c;
                    if (32'(sel_mode_c) >= NUM_MODES) begin
                        state_d = ST_RESP;
                    end else if (sel_mode_c == cur_mode_q) begin
                        state_d  = ST_RESP;
                        status_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                if (Frame_end) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                timer_d = '0;
                state_d = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                // A load on the timeout cycle still counts as success
                if (Load_config) begin
                    cur_mode_d  = pend_mode_q;
                    frame_cnt_d = '0;
                    state_d     = ST_SETTLE;
                end else if (timer_q == TIMER_W'(LOAD_TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_SETTLE: begin
                if (Frame_end) begin
                    if (frame_cnt_q >= FRAME_W'(SETTLE_FRAMES - 1)) begin
                        state_d  = ST_RESP;
                        status_d = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cfg_valid_d = (state_d == ST_WRITE);
        if (cfg_valid_d) begin
            cfg_addr_d = MODE_ADDR;
            cfg_data_d = pend_mode_d;
        end
        blank_d = is_blank_state(state_d);
        ack_a_d = (state_d == ST_RESP) && !gnt_b_d;
        ack_b_d = (state_d == ST_RESP) && gnt_b_d;
        busy_d  = (state_d != ST_IDLE);
    end

    assign Ack_a     = ack_a_q;
    assign Ack_b     = ack_b_q;
    assign Status    = status_q;
    assign Cfg_valid = cfg_valid_q;
    assign Cfg_addr  = cfg_addr_q;
    assign Cfg_data  = cfg_data_q;
    assign Blank     = blank_q;
    assign Busy      = busy_q;
    assign Cur_mode  = cur_mode_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Scoreboard bench for vga_mode_sequencer: expected Config writes and
// responses are queued at request time and popped as the DUT produces them.
module tb_vga_mode_sequencer;
    import vga_mode_sequencer_pkg::*;

    typedef struct packed {
        logic       is_b;
        logic       status;
        logic [1:0] mode;
    } resp_t;

    logic       Clk;
    logic       Rst;
    logic       Req_a, Req_b;
    logic [1:0] Mode_a, Mode_b;
    logic       Ack_a, Ack_b, Status;
    logic       Frame_end, Load_config;
    logic       Cfg_valid, Blank, Busy;
    logic [1:0] Cfg_addr, Cfg_data, Cur_mode;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ack_cnt_a = 0;
    int         ack_cnt_b = 0;
    resp_t      resp_q[$];
    logic [1:0] wr_q[$];

    vga_mode_sequencer dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Req_a       (Req_a),
        .Mode_a      (Mode_a),
        .Ack_a       (Ack_a),
        .Req_b       (Req_b),
        .Mode_b      (Mode_b),
        .Ack_b       (Ack_b),
        .Status      (Status),
        .Frame_end   (Frame_end),
        .Load_config (Load_config),
        .Cfg_valid   (Cfg_valid),
        .Cfg_addr    (Cfg_addr),
        .Cfg_data    (Cfg_data),
        .Blank       (Blank),
        .Busy        (Busy),
        .Cur_mode    (Cur_mode)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_frame();
        Frame_end = 1'b1;
        tick(1);
        Frame_end = 1'b0;
    endtask

    task automatic pulse_load();
        Load_config = 1'b1;
        tick(1);
        Load_config = 1'b0;
    endtask

    task automatic push_resp(input logic is_b, input logic status, input logic [1:0] mode);
        resp_t e;
        e.is_b   = is_b;
        e.status = status;
        e.mode   = mode;
        resp_q.push_back(e);
    endtask

    // Mid-cycle monitor: pops the scoreboard on writes/acks and tracks the blank window
    task automatic monitor_loop();
        resp_t      e;
        logic [1:0] w;
        logic       win;
        win = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                win = 1'b0;
            end else begin
                if (Cfg_valid) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_write", 32'(Cfg_valid), 0);
                    end else begin
                        w = wr_q.pop_front();
                        check("cfg_addr", 32'(Cfg_addr), 32'(MODE_ADDR));
                        check("cfg_data", 32'(Cfg_data), 32'(w));
                    end
                    win = 1'b1;
                end
                if (Ack_a || Ack_b) begin
                    if (Ack_a) ack_cnt_a++;
                    if (Ack_b) ack_cnt_b++;
                    if (resp_q.size() == 0) begin
                        check("unexpected_ack", 32'({Ack_b, Ack_a}), 0);
                    end else begin
                        e = resp_q.pop_front();
                        check("ack_id", 32'({Ack_b, Ack_a}), e.is_b ? 32'd2 : 32'd1);
                        check("status", 32'(Status), 32'(e.status));
                        check("cur_mode", 32'(Cur_mode), 32'(e.mode));
                    end
                    win = 1'b0;
                end
                check("blank", 32'(Blank), 32'(win));
            end
        end
    endtask

    // Requester: raise Req with Mode, drop it on the edge after Ack is seen
    task automatic run_req(input logic is_b, input logic [1:0] mode);
        int start;
        bit ok;
        ok    = 1'b0;
        start = is_b ? ack_cnt_b : ack_cnt_a;
        if (is_b) begin
            Mode_b = mode;
            Req_b  = 1'b1;
        end else begin
            Mode_a = mode;
            Req_a  = 1'b1;
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge Clk);
            #1;
            ok = ((is_b ? ack_cnt_b : ack_cnt_a) != start);
        end
        if (!ok) check(is_b ? "req_b_ack_timeout" : "req_a_ack_timeout", 0, 1);
        if (is_b) Req_b = 1'b0;
        else      Req_a = 1'b0;
    endtask

    // Drive one change from WAIT_FRAME onward: frame, write, then load+settle or timeout
    task automatic serve(input bit do_load);
        pulse_frame();
        if (do_load) begin
            tick(2);
            pulse_load();
            tick(2);
            pulse_frame();
            tick(2);
            pulse_frame();
        end else begin
            tick(16);
            check("no_ack_before_timeout", 32'(Ack_a | Ack_b), 0);
            tick(1);
            check("ack_at_timeout", 32'(Ack_a | Ack_b), 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_valid"}, 32'(Cfg_valid), 0);
        check({tag, "_cfg_addr"}, 32'(Cfg_addr), 0);
        check({tag, "_cfg_data"}, 32'(Cfg_data), 0);
        check({tag, "_blank"}, 32'(Blank), 0);
        check({tag, "_ack"}, 32'({Ack_b, Ack_a}), 0);
        check({tag, "_status"}, 32'(Status), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_cur_mode"}, 32'(Cur_mode), 32'(MODE_6X4));
    endtask

    initial begin
        Rst = 1'b1; Req_a = 1'b0; Req_b = 1'b0; Mode_a = '0; Mode_b = '0;
        Frame_end = 1'b0; Load_config = 1'b0;
        fork
            monitor_loop();
        join_none
        tick(2);
        check_reset_outputs("reset");
        Rst = 1'b0;
        tick(2);
        check_reset_outputs("idle");

        // B requests the mode already active: no write, ack the cycle after grant
        push_resp(1'b1, 1'b1, MODE_6X4);
        fork
            run_req(1'b1, MODE_6X4);
            begin tick(1); check("equal_ack_next_cycle", 32'(Ack_b), 1); end
        join
        tick(1);

        // Out-of-range mode is rejected without a write
        push_resp(1'b0, 1'b0, MODE_6X4);
        fork
            run_req(1'b0, 2'b11);
            begin tick(1); check("reject_ack_next_cycle", 32'(Ack_a), 1); end
        join
        tick(1);

        // Full change to 8x6 with directed frame/load timing
        wr_q.push_back(MODE_8X6);
        push_resp(1'b0, 1'b1, MODE_8X6);
        fork
            run_req(1'b0, MODE_8X6);
            begin
                tick(5);
                check("wait_frame_busy", 32'(Busy), 1);
                check("wait_frame_blank", 32'(Blank), 0);
                pulse_frame();
                check("t1_write_cycle", 32'(Cfg_valid), 1);
                tick(3);
                pulse_load();
                check("t1_cur_mode_loaded", 32'(Cur_mode), 32'(MODE_8X6));
                tick(4);
                pulse_frame();
                check("t1_no_ack_1st_frame", 32'(Ack_a), 0);
                tick(4);
                pulse_frame();
                check("t1_ack_2nd_frame", 32'(Ack_a), 1);
            end
        join
        tick(1);

        // Simultaneous requests: A favoured first, then B
        wr_q.push_back(MODE_10X86);
        push_resp(1'b0, 1'b1, MODE_10X86);
        wr_q.push_back(MODE_8X6);
        push_resp(1'b1, 1'b1, MODE_8X6);
        fork
            run_req(1'b0, MODE_10X86);
            run_req(1'b1, MODE_8X6);
            begin tick(1); serve(1'b1); tick(2); serve(1'b1); end
        join
        tick(1);

        // Repeat the simultaneous raise: the pointer now favours B
        wr_q.push_back(MODE_10X86);
        push_resp(1'b1, 1'b1, MODE_10X86);
        wr_q.push_back(MODE_6X4);
        push_resp(1'b0, 1'b1, MODE_6X4);
        fork
            run_req(1'b0, MODE_6X4);
            run_req(1'b1, MODE_10X86);
            begin tick(1); serve(1'b1); tick(2); serve(1'b1); end
        join
        tick(1);

        // Load never arrives: timeout, failure status, mode unchanged
        wr_q.push_back(MODE_8X6);
        push_resp(1'b0, 1'b0, MODE_6X4);
        fork
            run_req(1'b0, MODE_8X6);
            begin tick(1); serve(1'b0); end
        join
        tick(1);
        check("timeout_cur_mode", 32'(Cur_mode), 32'(MODE_6X4));

        // Reset during SETTLE abandons the change with no ack
        wr_q.push_back(MODE_10X86);
        Mode_a = MODE_10X86;
        Req_a  = 1'b1;
        tick(1);
        pulse_frame();
        tick(2);
        pulse_load();
        check("settle_cur_mode", 32'(Cur_mode), 32'(MODE_10X86));
        check("settle_blank", 32'(Blank), 1);
        tick(1);
        Rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        Req_a = 1'b0;
        tick(2);
        Rst = 1'b0;
        tick(3);
        check_reset_outputs("post_reset");

        // After reset both requesters ask for the active mode: A first
        push_resp(1'b0, 1'b1, MODE_6X4);
        push_resp(1'b1, 1'b1, MODE_6X4);
        fork
            run_req(1'b0, MODE_6X4);
            run_req(1'b1, MODE_6X4);
        join
        tick(3);

        check("resp_queue_drained", 32'(resp_q.size()), 0);
        check("write_queue_drained", 32'(wr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
